// File: rtl/pipeline_pkg.sv
// Shared constants for the RV32I pipeline control slice: opcodes, IF/ID select
// encodings, the NOP word and the hazard-controller FSM state encoding.
package pipeline_pkg;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_S     = 7'b0100011;
    localparam logic [6:0] OPC_B     = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    typedef logic [1:0] if_sel_t;
    localparam if_sel_t IF_SEL_FETCH  = 2'b00;
    localparam if_sel_t IF_SEL_NOP    = 2'b01;
    localparam if_sel_t IF_SEL_FREEZE = 2'b10;

    // ADD x0,x0,x0
    localparam logic [31:0] NOP_WORD = 32'h0000_0033;

    typedef logic [1:0] ctrl_state_t;
    localparam ctrl_state_t ST_RUN   = 2'd0;
    localparam ctrl_state_t ST_STALL = 2'd1;
    localparam ctrl_state_t ST_FLUSH = 2'd2;

    function automatic logic uses_rs1(input logic [6:0] opc);
        return !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return (opc == OPC_R) || (opc == OPC_S) || (opc == OPC_B);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the hazard controller and the IF/ID/EX datapath: hazard
// sources from ID/EX in, fetch-stage and ID/EX control out.
interface pipeline_hazard_ctrl_if;
    import pipeline_pkg::*;

    logic [31:0] Instruction_Register_ID;
    logic [4:0]  Rd_EX;
    logic        Mem_Read_EX;
    logic        Branch_Taken_EX;
    logic [31:0] Branch_Target_EX;

    logic        Do_Stall;
    logic        Is_Branch_Taken;
    if_sel_t     MUX_IF_PM;
    logic [31:0] Jump_Address;
    logic        Bubble_EX;

    modport master (
        input  Instruction_Register_ID, Rd_EX, Mem_Read_EX,
               Branch_Taken_EX, Branch_Target_EX,
        output Do_Stall, Is_Branch_Taken, MUX_IF_PM, Jump_Address, Bubble_EX
    );

    modport slave (
        output Instruction_Register_ID, Rd_EX, Mem_Read_EX,
               Branch_Taken_EX, Branch_Target_EX,
        input  Do_Stall, Is_Branch_Taken, MUX_IF_PM, Jump_Address, Bubble_EX
    );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard decode: flags an ID instruction that reads the register an
// EX-stage load is about to write.
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [4:0]  rd_ex,
    input  logic        mem_read_ex,
    output logic        hazard
);

    logic [6:0] opc;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use_rs1;
    logic       use_rs2;
    logic       unused_instr_bits;

    assign opc     = instr[6:0];
    assign rs1     = instr[19:15];
    assign rs2     = instr[24:20];
    assign use_rs1 = uses_rs1(opc);
    assign use_rs2 = uses_rs2(opc);

    // funct/immediate/rd fields play no part in the dependency check
    assign unused_instr_bits = ^{instr[31:25], instr[14:7]};

    assign hazard = mem_read_ex & (rd_ex != 5'd0) &
                    ((use_rs1 & (rs1 == rd_ex)) | (use_rs2 & (rs2 == rd_ex)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall and EX redirect/flush sequencing
// with Mealy outputs. Optional perf counters via PIPELINE_PERF_COUNTERS_EN.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int LOAD_USE_STALL      = 1,
    parameter int BRANCH_FLUSH_CYCLES = 1
)(
    input  logic Clock,
    input  logic Reset,
    pipeline_hazard_ctrl_if.master ctrl
`ifdef PIPELINE_PERF_COUNTERS_EN
    ,
    output logic [31:0] Stall_Count,
    output logic [31:0] Flush_Count
`endif
);

    localparam bit          STALL_EN   = (LOAD_USE_STALL > 1);
    localparam bit          FLUSH_EN   = (BRANCH_FLUSH_CYCLES > 1);
    localparam logic [1:0]  STALL_LAST = 2'(LOAD_USE_STALL - 2);
    localparam logic [1:0]  FLUSH_LAST = 2'(BRANCH_FLUSH_CYCLES - 2);

    ctrl_state_t state;
    ctrl_state_t state_nxt;
    logic [1:0]  cnt;
    logic        cnt_clr;
    logic        cnt_inc;
    logic        hazard;

    logic        do_stall;
    logic        is_branch_taken;
    if_sel_t     mux_sel;
    logic [31:0] jump_address;
    logic        bubble_ex;

    hazard_detect u_hazard_detect (
        .instr       (ctrl.Instruction_Register_ID),
        .rd_ex       (ctrl.Rd_EX),
        .mem_read_ex (ctrl.Mem_Read_EX),
        .hazard      (hazard)
    );

    // Outputs are forced low while Reset is held so a live hazard cannot leak out
    always_comb begin
        do_stall        = 1'b0;
        is_branch_taken = 1'b0;
        mux_sel         = IF_SEL_FETCH;
        jump_address    = 32'd0;
        bubble_ex       = 1'b0;
        state_nxt       = state;
        cnt_clr         = 1'b0;
        cnt_inc         = 1'b0;

        if (Reset) begin
            if (state == ST_FLUSH) begin
                do_stall = 1'b1;
                mux_sel  = IF_SEL_NOP;
                if (cnt == FLUSH_LAST) state_nxt = ST_RUN;
                else                   cnt_inc   = 1'b1;
            end else if (ctrl.Branch_Taken_EX) begin
                is_branch_taken = 1'b1;
                jump_address    = ctrl.Branch_Target_EX;
                mux_sel         = IF_SEL_NOP;
                bubble_ex       = 1'b1;
                state_nxt       = FLUSH_EN ? ST_FLUSH : ST_RUN;
                cnt_clr         = 1'b1;
            end else if ((state == ST_STALL) || hazard) begin
                do_stall  = 1'b1;
                mux_sel   = IF_SEL_FREEZE;
                bubble_ex = 1'b1;
                if (state == ST_STALL) begin
                    if (cnt == STALL_LAST) state_nxt = ST_RUN;
                    else                   cnt_inc   = 1'b1;
                end else begin
                    state_nxt = STALL_EN ? ST_STALL : ST_RUN;
                    cnt_clr   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= ST_RUN;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            if (cnt_clr)
                cnt <= 2'd0;
            else if (cnt_inc)
                cnt <= (cnt == 2'b11) ? cnt : cnt + 2'd1;
        end
    end

    assign ctrl.Do_Stall        = do_stall;
    assign ctrl.Is_Branch_Taken = is_branch_taken;
    assign ctrl.MUX_IF_PM       = mux_sel;
    assign ctrl.Jump_Address    = jump_address;
    assign ctrl.Bubble_EX       = bubble_ex;

`ifdef PIPELINE_PERF_COUNTERS_EN
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Stall_Count <= 32'd0;
            Flush_Count <= 32'd0;
        end else begin
            if (do_stall && (mux_sel == IF_SEL_FREEZE))
                Stall_Count <= Stall_Count + 32'd1;
            if (mux_sel == IF_SEL_NOP)
                Flush_Count <= Flush_Count + 32'd1;
        end
    end
`endif

endmodule
